demux_stream: RTL and testbench
===============================

DEMUX_STREAM -- requirements
Module: demux_stream

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits, range 1..64.
REQ-002 Parameter CH, default 4: output channel count, range 2..16.
REQ-003 Parameter SELW, default 2: select width; shall satisfy 2^SELW >= CH, elaboration error otherwise.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  input word present.
REQ-007 in_ready  output  1  block accepts input this cycle.
REQ-008 in_data  input  WIDTH  input word.
REQ-009 sel  input  SELW  destination channel, qualified by in_valid.
REQ-010 out_valid  output  CH  per-channel word present, bit k = channel k.
REQ-011 out_ready  input  CH  per-channel sink accepts, bit k = channel k.
REQ-012 out_data  output  CH*WIDTH  channel k word on bits [k*WIDTH +: WIDTH].
REQ-013 err  output  1  one-cycle pulse: illegal select consumed.

Function
REQ-014 Each channel shall have one output holding register plus a valid flag (slot k).
REQ-015 Slot k is "free" when out_valid[k]=0 or out_ready[k]=1.
REQ-016 For legal sel (sel < CH): in_ready = free(sel), combinational from sel, out_valid, out_ready only, never from in_valid.
REQ-017 Transfer on in_valid & in_ready: in_data loaded into slot sel; out_valid[sel]=1 next cycle; latency exactly 1 cycle.
REQ-018 Output handshake on out_valid[k] & out_ready[k]: slot k cleared next cycle unless refilled the same cycle.
REQ-019 Simultaneous drain and refill of slot k: slot holds new word, out_valid[k] stays 1; one word per cycle sustained per channel.
REQ-020 While out_valid[k]=1 and out_ready[k]=0, out_data slice k shall hold stable.
REQ-021 Slots are independent; a stalled channel shall not block transfers to other channels.
REQ-022 Illegal sel (sel >= CH): in_ready=1, word discarded, no slot changes, err=1 in the following cycle only.
REQ-023 err=0 in all other cycles; back-to-back illegal words produce err high for consecutive cycles.
REQ-024 out_data slice k with out_valid[k]=0 retains last loaded value (0 after reset).
REQ-025 No combinational path from in_valid or in_data to any output.

Reset
REQ-026 On rst_n=0, asynchronously: out_valid=0, out_data=0, err=0; in_ready then follows REQ-016 with all slots free.
REQ-027 Reset mid-transfer shall discard all held words; no output handshake completes while rst_n=0.
REQ-028 Release of rst_n is synchronised externally; first transfer allowed on first rising edge after release.

Configuration
REQ-029 Macro DEMUX_BCAST_EN, when defined, adds input port bcast (1 bit, qualified by in_valid).
REQ-030 With DEMUX_BCAST_EN and bcast=1: sel ignored, in_ready = AND of free(k) for all k, word loaded into every slot in one cycle, err not asserted.
REQ-031 With DEMUX_BCAST_EN and bcast=0, and without the macro (port absent), behaviour is REQ-016..REQ-024 unchanged.

Verification
REQ-032 Reset then in_data=0xA5, sel=2, all out_ready=0 -> next cycle out_valid=4'b0100, slice 2=0xA5, in_ready for sel=2 low, for sel=0 high.
REQ-033 sel=1 every cycle, out_ready[1]=1, data 0x01..0x10 -> 16 words on channel 1 in order, one per cycle, in_ready constantly 1.
REQ-034 Channel 3 stalled holding 0x3C, then words to channels 0 and 1 -> both delivered; slice 3 stays 0x3C until out_ready[3]=1.
REQ-035 CH=3, SELW=2, sel=3 with in_valid=1 -> in_ready=1, err=1 next cycle only, out_valid unchanged.
REQ-036 rst_n pulled low between clock edges with out_valid=4'b1011 -> out_valid=0, out_data=0 immediately, without a clock edge.
REQ-037 DEMUX_BCAST_EN, bcast=1, data 0x77, channel 2 stalled full -> in_ready=0; release channel 2 -> next cycle all four slices 0x77, out_valid=4'b1111.

Source files
------------

// File: rtl/demux_stream_if.sv
// Stream demux bus: one input stream fanned out to CH output slots.
// The bcast signal exists only when DEMUX_BCAST_EN is defined.
interface demux_stream_if #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = 2
);
  logic                in_valid;
  logic                in_ready;
  logic [WIDTH-1:0]    in_data;
  logic [SELW-1:0]     sel;
  logic [CH-1:0]       out_valid;
  logic [CH-1:0]       out_ready;
  logic [CH*WIDTH-1:0] out_data;
  logic                err;
`ifdef DEMUX_BCAST_EN
  logic                bcast;

  modport master (
    output in_valid, in_data, sel, out_ready, bcast,
    input  in_ready, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready, bcast,
    output in_ready, out_valid, out_data, err
  );
`else
  modport master (
    output in_valid, in_data, sel, out_ready,
    input  in_ready, out_valid, out_data, err
  );

  modport slave (
    input  in_valid, in_data, sel, out_ready,
    output in_ready, out_valid, out_data, err
  );
`endif
endinterface

// File: rtl/demux_stream.sv
// One-deep holding slot per channel, routed by sel; err flags illegal sel.
// Optional broadcast input when DEMUX_BCAST_EN is defined.
module demux_stream #(
  parameter int WIDTH = 8,
  parameter int CH    = 4,
  parameter int SELW  = 2
) (
  input logic           clk,
  input logic           rst_n,
  demux_stream_if.slave s
);

  localparam int NSEL = 1 << SELW;
  localparam logic [SELW:0] CH_L = (SELW+1)'(CH);

  if (NSEL < CH) begin : g_selw_chk
    $error("demux_stream: 2**SELW must be >= CH");
  end

  if (CH < 2 || CH > 16 || WIDTH < 1 || WIDTH > 64) begin : g_rng_chk
    $error("demux_stream: WIDTH or CH out of range");
  end

  logic [CH-1:0]             vld_q, vld_d;
  logic [CH-1:0][WIDTH-1:0]  dat_q, dat_d;
  logic                      err_q, err_d;
  logic [NSEL-1:0]           free;
  logic                      legal;
  logic                      bc;
  logic                      rdy;
  logic                      acc;

`ifdef DEMUX_BCAST_EN
  assign bc = s.bcast;
`else
  assign bc = 1'b0;
`endif

  // Unused select codes read as free so illegal words are always taken.
  always_comb begin
    free = '1;
    for (int k = 0; k < CH; k++) begin
      free[k] = ~vld_q[k] | s.out_ready[k];
    end
  end

  assign legal = {1'b0, s.sel} < CH_L;
  assign rdy   = bc ? &free[CH-1:0] : free[s.sel];
  assign acc   = s.in_valid & rdy;

  always_comb begin
    vld_d = vld_q & ~s.out_ready;
    dat_d = dat_q;
    for (int k = 0; k < CH; k++) begin
      if (acc && (bc || (legal && s.sel == SELW'(k)))) begin
        vld_d[k] = 1'b1;
        dat_d[k] = s.in_data;
      end
    end
  end

  assign err_d = acc & ~bc & ~legal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      dat_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
      err_q <= err_d;
    end
  end

  assign s.in_ready  = rdy;
  assign s.out_valid = vld_q;
  assign s.out_data  = dat_q;
  assign s.err       = err_q;

endmodule

// File: tb/tb_demux_stream.sv
// Bench for demux_stream: a 4-channel and a 3-channel instance share stimulus,
// checked every cycle against per-channel word queues plus literal scenarios.
module tb_demux_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  demux_stream_if #(.WIDTH(8), .CH(4), .SELW(2)) ia ();
  demux_stream_if #(.WIDTH(8), .CH(3), .SELW(2)) ib ();

  demux_stream #(.WIDTH(8), .CH(4), .SELW(2)) u_a (
    .clk(clk), .rst_n(rst_n), .s(ia)
  );
  demux_stream #(.WIDTH(8), .CH(3), .SELW(2)) u_b (
    .clk(clk), .rst_n(rst_n), .s(ib)
  );

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  bit         in_v;
  logic [7:0] in_d;
  logic [1:0] in_sel;
  logic [3:0] ordy_a;
  logic [3:0] ordy_b;
  bit         bc_s;

  // model: index d*4+k, each queue holds the words waiting on that output
  logic [7:0] mq [8][$];
  logic [7:0] last [8];
  bit         merr [2];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d,
                       input logic [1:0] s, input logic [3:0] oa,
                       input logic [2:0] ob);
    in_v = v; in_d = d; in_sel = s;
    ordy_a = oa; ordy_b = {1'b0, ob};
    ia.in_valid = v; ia.in_data = d; ia.sel = s; ia.out_ready = oa;
    ib.in_valid = v; ib.in_data = d; ib.sel = s; ib.out_ready = ob;
`ifdef DEMUX_BCAST_EN
    ia.bcast = bc_s; ib.bcast = bc_s;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic bit exp_rdy(input int d, input logic [3:0] o);
    bit r;
    int n;
    n = nch(d);
    if (bc_s) begin
      r = 1'b1;
      for (int k = 0; k < n; k++)
        if (mq[d*4+k].size() != 0 && !o[k]) r = 1'b0;
    end else if (int'(in_sel) < n) begin
      r = (mq[d*4+int'(in_sel)].size() == 0) || o[in_sel];
    end else begin
      r = 1'b1;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      mq[i].delete();
      last[i] = 8'h00;
    end
    merr[0] = 1'b0;
    merr[1] = 1'b0;
  endtask

  task automatic model_step();
    logic [3:0] o;
    bit rdy, acc, lg;
    int n;
    for (int d = 0; d < 2; d++) begin
      n = nch(d);
      o = (d == 0) ? ordy_a : ordy_b;
      rdy = exp_rdy(d, o);
      acc = in_v && rdy;
      lg = int'(in_sel) < n;
      merr[d] = acc && !bc_s && !lg;
      for (int k = 0; k < n; k++) begin
        if (mq[d*4+k].size() != 0 && o[k]) void'(mq[d*4+k].pop_front());
        if (acc && (bc_s || (lg && int'(in_sel) == k))) begin
          mq[d*4+k].push_back(in_d);
          last[d*4+k] = in_d;
        end
      end
    end
  endtask

  task automatic compare();
    logic [3:0]  ev;
    logic [31:0] ed;
    for (int d = 0; d < 2; d++) begin
      ev = '0;
      ed = '0;
      for (int k = 0; k < nch(d); k++) begin
        ev[k] = mq[d*4+k].size() != 0;
        ed[k*8 +: 8] = last[d*4+k];
      end
      if (d == 0) begin
        chk("a_out_valid", 64'(ia.out_valid), 64'(ev));
        chk("a_out_data", 64'(ia.out_data), 64'(ed));
        chk("a_err", 64'(ia.err), 64'(merr[0]));
        chk("a_in_ready", 64'(ia.in_ready), 64'(exp_rdy(0, ordy_a)));
      end else begin
        chk("b_out_valid", 64'(ib.out_valid), 64'(ev));
        chk("b_out_data", 64'(ib.out_data), 64'(ed));
        chk("b_err", 64'(ib.err), 64'(merr[1]));
        chk("b_in_ready", 64'(ib.in_ready), 64'(exp_rdy(1, ordy_b)));
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  initial begin
    @(negedge clk);
    while (!done) begin
      compare();
      @(negedge clk);
    end
  end

  initial begin
    rst_n = 1'b0;
    bc_s = 1'b0;
    drive(0, 8'h00, 2'd0, 4'h0, 3'h0);
    #2;
    chk("rst_out_valid", 64'(ia.out_valid), 64'h0);
    chk("rst_out_data", 64'(ia.out_data), 64'h0);
    chk("rst_err", 64'(ia.err), 64'h0);
    chk("rst_in_ready", 64'(ia.in_ready), 64'h1);
    step(); step();
    rst_n = 1'b1;

    // single word to channel 2
    drive(1, 8'hA5, 2'd2, 4'h0, 3'h0);
    step();
    drive(0, 8'h00, 2'd2, 4'h0, 3'h0);
    #1 chk("a5_rdy_sel2", 64'(ia.in_ready), 64'h0);
    drive(0, 8'h00, 2'd0, 4'h0, 3'h0);
    #1 chk("a5_rdy_sel0", 64'(ia.in_ready), 64'h1);
    chk("a5_valid", 64'(ia.out_valid), 64'h4);
    chk("a5_slice2", 64'(ia.out_data[23:16]), 64'hA5);
    step();
    drive(0, 8'h00, 2'd0, 4'hF, 3'h7);
    step();

    // sustained stream on channel 1
    drive(1, 8'h01, 2'd1, 4'b0010, 3'b010);
    for (int i = 1; i <= 16; i++) begin
      #1 chk("strm_rdy", 64'(ia.in_ready), 64'h1);
      step();
      chk("strm_valid", 64'(ia.out_valid[1]), 64'h1);
      chk("strm_data", 64'(ia.out_data[15:8]), 64'(i));
      if (i < 16) drive(1, 8'(i + 1), 2'd1, 4'b0010, 3'b010);
      else drive(0, 8'h00, 2'd0, 4'hF, 3'h7);
    end
    step();

    // stalled channel 3 does not block 0 and 1
    drive(1, 8'h3C, 2'd3, 4'h0, 3'h0);
    step();
    drive(1, 8'h11, 2'd0, 4'b0011, 3'b011);
    #1 chk("stall_rdy0", 64'(ia.in_ready), 64'h1);
    step();
    chk("stall_v0", 64'(ia.out_valid[0]), 64'h1);
    chk("stall_d0", 64'(ia.out_data[7:0]), 64'h11);
    chk("stall_d3a", 64'(ia.out_data[31:24]), 64'h3C);
    drive(1, 8'h22, 2'd1, 4'b0011, 3'b011);
    step();
    chk("stall_v1", 64'(ia.out_valid[1]), 64'h1);
    chk("stall_d1", 64'(ia.out_data[15:8]), 64'h22);
    chk("stall_v3", 64'(ia.out_valid[3]), 64'h1);
    chk("stall_d3b", 64'(ia.out_data[31:24]), 64'h3C);
    drive(0, 8'h00, 2'd3, 4'b0011, 3'b011);
    #1 chk("stall_rdy3", 64'(ia.in_ready), 64'h0);
    step();
    chk("stall_d3c", 64'(ia.out_data[31:24]), 64'h3C);
    drive(0, 8'h00, 2'd3, 4'b1000, 3'b000);
    #1 chk("stall_rdy3r", 64'(ia.in_ready), 64'h1);
    step();
    chk("stall_v3off", 64'(ia.out_valid[3]), 64'h0);
    chk("stall_d3keep", 64'(ia.out_data[31:24]), 64'h3C);
    drive(0, 8'h00, 2'd0, 4'hF, 3'h7);
    step();

    // illegal select on the 3-channel instance
    drive(1, 8'h5B, 2'd0, 4'h0, 3'h0);
    step();
    drive(1, 8'h5A, 2'd3, 4'h0, 3'h0);
    #1 chk("ill_rdy", 64'(ib.in_ready), 64'h1);
    step();
    drive(0, 8'h00, 2'd0, 4'h0, 3'h0);
    chk("ill_err1", 64'(ib.err), 64'h1);
    chk("ill_valid1", 64'(ib.out_valid), 64'h1);
    step();
    chk("ill_err0", 64'(ib.err), 64'h0);
    chk("ill_valid0", 64'(ib.out_valid), 64'h1);
    drive(0, 8'h00, 2'd0, 4'hF, 3'h7);
    step();

    // asynchronous reset between edges
    drive(1, 8'hC0, 2'd0, 4'h0, 3'h0);
    step();
    drive(1, 8'hC1, 2'd1, 4'h0, 3'h0);
    step();
    drive(1, 8'hC3, 2'd3, 4'h0, 3'h0);
    step();
    drive(0, 8'h00, 2'd0, 4'h0, 3'h0);
    #1 chk("ar_pre", 64'(ia.out_valid), 64'hB);
    #1 rst_n = 1'b0;
    #1 chk("ar_valid", 64'(ia.out_valid), 64'h0);
    chk("ar_data", 64'(ia.out_data), 64'h0);
    chk("ar_b_valid", 64'(ib.out_valid), 64'h0);
    chk("ar_b_err", 64'(ib.err), 64'h0);
    step();
    rst_n = 1'b1;

`ifdef DEMUX_BCAST_EN
    drive(1, 8'h22, 2'd2, 4'h0, 3'h0);
    step();
    bc_s = 1'b1;
    drive(1, 8'h77, 2'd0, 4'h0, 3'h0);
    #1 chk("bc_rdy0", 64'(ia.in_ready), 64'h0);
    step();
    chk("bc_hold", 64'(ia.out_valid), 64'h4);
    drive(1, 8'h77, 2'd0, 4'b0100, 3'b100);
    #1 chk("bc_rdy1", 64'(ia.in_ready), 64'h1);
    step();
    bc_s = 1'b0;
    drive(0, 8'h00, 2'd0, 4'h0, 3'h0);
    chk("bc_valid", 64'(ia.out_valid), 64'hF);
    chk("bc_data", 64'(ia.out_data), 64'h77777777);
    chk("bc_b_valid", 64'(ib.out_valid), 64'h7);
    chk("bc_err", 64'(ia.err), 64'h0);
    drive(0, 8'h00, 2'd0, 4'hF, 3'h7);
    step();
`endif

    // randomized traffic with one mid-stream reset
    for (int c = 0; c < 3000; c++) begin
`ifdef DEMUX_BCAST_EN
      bc_s = ($urandom_range(0, 7) == 0);
`endif
      drive(($urandom_range(0, 3) != 0), 8'($urandom),
            2'($urandom), 4'($urandom), 3'($urandom));
      if (c == 1500) #2 rst_n = 1'b0;
      step();
      rst_n = 1'b1;
    end

    bc_s = 1'b0;
    drive(0, 8'h00, 2'd0, 4'h0, 3'h0);
    step();
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
